// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C initiator (START, address+R/W, one data byte, STOP) on open-drain sda/scl.
// Define I2C_STRETCH_EN to let a target stretch SCL by holding the quarter counter at the end of q2.
module i2c_master #(
  parameter int QTR_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] adress,
  input  logic [7:0] data,
  output logic [7:0] out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda,
  output logic       o_scl,
  output logic       o_sda_en,
  output logic       o_scl_en
);
  localparam int QW = $clog2(QTR_CYCLES);
  typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP} state_t;
  state_t r_state, w_next;
  logic [QW-1:0] r_qcnt;
  logic [1:0] r_q, r_sda_s, r_scl_s;
  logic [2:0] r_bit;
  logic [7:0] r_abyte, r_data, r_sh, r_out;
  logic r_smp, r_done, r_ack_err;
  logic w_qend, w_hold, w_tick, w_sample, w_slot_end;
  assign o_sda = 1'b0;
  assign o_scl = 1'b0;
  assign out = r_out;
  assign done = r_done;
  assign ack_err = r_ack_err;
  assign busy = r_state != IDLE;
  assign w_qend = r_qcnt == QW'(QTR_CYCLES - 1);
`ifdef I2C_STRETCH_EN
  // Holding only on the last q2 cycle hides the synchronizer latency on an unstretched bus.
  assign w_hold = r_q == 2'd2 && w_qend && !r_scl_s[1];
`else
  assign w_hold = 1'b0 & ~r_scl_s[1];
`endif
  assign w_tick = w_qend && !w_hold;
  assign w_sample = w_tick && r_q == 2'd2;
  assign w_slot_end = w_tick && r_q == 2'd3;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = start ? START : IDLE;
    else if (w_slot_end)
      case (r_state)
        START:   w_next = ADDR;
        ADDR:    w_next = &r_bit ? AACK : ADDR;
        AACK:    w_next = r_smp ? STOP : r_abyte[0] ? RDATA : WDATA;
        WDATA:   w_next = &r_bit ? WACK : WDATA;
        WACK:    w_next = STOP;
        RDATA:   w_next = &r_bit ? RNACK : RDATA;
        RNACK:   w_next = STOP;
        default: w_next = IDLE;
      endcase
    o_scl_en = r_state == START ? r_q == 2'd3 : r_state == STOP ? r_q == 2'd0 : r_state != IDLE && !r_q[1];
    o_sda_en = r_state == START ? r_q[1] : r_state == STOP ? r_q != 2'd3 :
               r_state == ADDR ? !r_abyte[~r_bit] : r_state == WDATA ? !r_data[~r_bit] : 1'b0;
  end
  always_ff @(posedge clk) begin
    r_sda_s <= {r_sda_s[0], i_sda};
    r_scl_s <= {r_scl_s[0], i_scl};
    r_done <= 1'b0;
    if (rst) begin
      r_qcnt <= '0;
      r_q <= '0;
      r_bit <= '0;
      r_out <= '0;
      r_ack_err <= 1'b0;
      r_sda_s <= 2'b11;
      r_scl_s <= 2'b11;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_abyte <= {adress, rw};
        r_data <= data;
        r_ack_err <= 1'b0;
      end
    end else begin
      if (!w_hold) r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
      if (w_tick) r_q <= r_q + 1'b1;
      if (w_sample) begin
        r_smp <= r_sda_s[1];
        if (r_state == RDATA) r_sh <= {r_sh[6:0], r_sda_s[1]};
      end
      if (w_slot_end) begin
        if (r_state inside {ADDR, WDATA, RDATA}) r_bit <= r_bit + 1'b1;
        if (r_state inside {AACK, WACK} && r_smp) r_ack_err <= 1'b1;
        if (r_state == STOP) begin
          r_done <= 1'b1;
          if (r_abyte[0] && !r_ack_err) r_out <= r_sh;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed checks of i2c_master (QTR_CYCLES=4) against a pulled-up bus and a responder at 0x27.
module tb_i2c_master;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] adress = '0;
  logic [7:0] data = '0;
  logic [7:0] out;
  logic busy, done, ack_err, o_sda, o_scl, o_sda_en, o_scl_en;
  logic t_sda_low = 1'b0, t_scl_low = 1'b0, t_stretch = 1'b0;
  logic [6:0] t_addr = 7'h27;
  logic [7:0] t_rdata = 8'h3C;
  logic [7:0] mon_addr, mon_data, t_sh;
  logic t_rd, t_match, rnack_sda;
  int t_bit, t_phase, n_rise, t_cnt, clr_ack;
  int clr_req = 0, checks = 0, errors = 0;
  wire sda_bus = ~(o_sda_en | t_sda_low);
  wire scl_bus = ~(o_scl_en | t_scl_low);
  // The responder clocks off the master's own SCL drive so its bit count survives its own stretching.
  wire t_scl = ~o_scl_en;

  i2c_master #(.QTR_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .adress(adress), .data(data),
    .out(out), .busy(busy), .done(done), .ack_err(ack_err),
    .i_sda(sda_bus), .i_scl(scl_bus), .o_sda(o_sda), .o_scl(o_scl),
    .o_sda_en(o_sda_en), .o_scl_en(o_scl_en)
  );

  initial forever #5 clk = ~clk;

  initial begin
    logic p_scl, p_sda;
    p_scl = 1'b1; p_sda = 1'b1; t_phase = 0; t_bit = 0; n_rise = 0; t_cnt = 0; clr_ack = 0;
    mon_addr = '0; mon_data = '0; t_sh = '0; t_rd = 1'b0; t_match = 1'b0; rnack_sda = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_ack != clr_req) begin
        clr_ack = clr_req; t_phase = 0; t_bit = 0; t_sda_low = 1'b0; t_scl_low = 1'b0;
        t_cnt = 0; n_rise = 0; mon_addr = '0; mon_data = '0; rnack_sda = 1'b0;
      end
      if (t_cnt > 0) begin
        t_cnt--;
        if (t_cnt == 0) t_scl_low = 1'b0;
      end
      if (p_scl && t_scl && p_sda && !sda_bus) begin
        t_phase = 1; t_bit = 0;
      end else if (p_scl && t_scl && !p_sda && sda_bus) t_phase = 0;
      else if (!p_scl && t_scl) begin
        n_rise++;
        if (t_phase != 0) begin
          if (t_bit < 8) t_sh = {t_sh[6:0], sda_bus};
          else if (t_phase == 2 && t_rd) rnack_sda = sda_bus;
          t_bit++;
        end
      end else if (p_scl && !t_scl && t_phase != 0) begin
        if (t_stretch && t_phase == 1 && t_bit == 3) begin
          t_scl_low = 1'b1; t_cnt = 28;
        end
        t_sda_low = 1'b0;
        if (t_bit == 8) begin
          if (t_phase == 1) begin
            mon_addr = t_sh; t_rd = t_sh[0]; t_match = t_sh[7:1] == t_addr; t_sda_low = t_match;
          end else begin
            mon_data = t_sh; t_sda_low = !t_rd;
          end
        end else if (t_bit == 9) begin
          t_bit = 0;
          if (t_phase == 1 && t_match) begin
            t_phase = 2; t_sda_low = t_rd && !t_rdata[7];
          end else t_phase = 0;
        end else if (t_phase == 2 && t_rd && t_bit > 0) t_sda_low = !t_rdata[7 - t_bit];
      end
      p_scl = t_scl; p_sda = sda_bus;
    end
  end

  task automatic run(input logic r, input logic [6:0] a, input logic [7:0] d, input int pulse_at,
                     input int rst_at, output int cyc, output logic b0);
    clr_req++;
    @(negedge clk);
    rw = r; adress = a; data = d; start = 1'b1;
    @(posedge clk); #1;
    b0 = busy; start = 1'b0; cyc = 0;
    while (!done && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
      start = cyc == pulse_at;
      if (start) begin
        rw = ~r; adress = 7'h11; data = 8'h00;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({o_sda_en, o_scl_en} !== 2'b00) begin errors++; $display("FAIL reset_lines en=%b want 00", {o_sda_en, o_scl_en}); end
    checks++; if ({busy, done, ack_err} !== 3'b000) begin errors++; $display("FAIL reset_flags busy/done/ack_err=%b want 000", {busy, done, ack_err}); end
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out); end
    checks++; if ({o_sda, o_scl} !== 2'b00) begin errors++; $display("FAIL drive_values got %b want 00", {o_sda, o_scl}); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write(input logic [7:0] d);
    int cyc; logic b0;
    run(1'b0, 7'h27, d, -1, -1, cyc, b0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL wr_busy_accept got %b want 1", b0); end
    checks++; if (cyc !== 320) begin errors++; $display("FAIL wr_done_cycle got %0d want 320", cyc); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL wr_ack_err got %b want 0", ack_err); end
    checks++; if (mon_addr !== 8'h4E) begin errors++; $display("FAIL wr_bus_addr got %h want 4e", mon_addr); end
    checks++; if (mon_data !== d) begin errors++; $display("FAIL wr_bus_data got %h want %h", mon_data, d); end
    checks++; if (n_rise !== 19) begin errors++; $display("FAIL wr_scl_pulses got %0d want 19", n_rise); end
    checks++; if ({busy, o_sda_en, o_scl_en} !== 3'b000) begin errors++; $display("FAIL wr_end_idle busy/sda_en/scl_en=%b want 000", {busy, o_sda_en, o_scl_en}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse got %b want 0", done); end
  endtask

  task automatic test_read;
    int cyc; logic b0;
    run(1'b1, 7'h27, 8'hFF, -1, -1, cyc, b0);
    checks++; if (cyc !== 320) begin errors++; $display("FAIL rd_done_cycle got %0d want 320", cyc); end
    checks++; if (out !== 8'h3C) begin errors++; $display("FAIL rd_out got %h want 3c", out); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL rd_ack_err got %b want 0", ack_err); end
    checks++; if (mon_addr !== 8'h4F) begin errors++; $display("FAIL rd_bus_addr got %h want 4f", mon_addr); end
    checks++; if (rnack_sda !== 1'b1) begin errors++; $display("FAIL rd_master_nack got %b want 1", rnack_sda); end
  endtask

  task automatic test_nack;
    int cyc; logic b0;
    run(1'b0, 7'h50, 8'hFF, -1, -1, cyc, b0);
    checks++; if (cyc !== 176) begin errors++; $display("FAIL nack_done_cycle got %0d want 176", cyc); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_ack_err got %b want 1", ack_err); end
    checks++; if (mon_addr !== 8'hA0) begin errors++; $display("FAIL nack_bus_addr got %h want a0", mon_addr); end
    checks++; if (n_rise !== 10) begin errors++; $display("FAIL nack_scl_pulses got %0d want 10", n_rise); end
    checks++; if (mon_data !== 8'h00) begin errors++; $display("FAIL nack_no_data got %h want 00", mon_data); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack_err_held got %b want 1", ack_err); end
  endtask

  task automatic test_ignored_start;
    int cyc, extra; logic b0;
    run(1'b0, 7'h27, 8'hA5, 100, -1, cyc, b0);
    checks++; if (cyc !== 320) begin errors++; $display("FAIL ign_done_cycle got %0d want 320", cyc); end
    checks++; if (mon_addr !== 8'h4E || mon_data !== 8'hA5) begin errors++; $display("FAIL ign_bus_bytes got %h %h want 4e a5", mon_addr, mon_data); end
    extra = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0 || busy !== 1'b0) begin errors++; $display("FAIL ign_queued extra_done=%0d busy=%b want 0 0", extra, busy); end
  endtask

  task automatic test_reset_mid;
    int cyc; logic b0;
    run(1'b0, 7'h27, 8'hA5, -1, 150, cyc, b0);
    checks++; if (cyc !== 150) begin errors++; $display("FAIL rstmid_reached got %0d want 150", cyc); end
    @(posedge clk); #1;
    checks++; if ({o_sda_en, o_scl_en, busy, done} !== 4'b0000) begin errors++; $display("FAIL rstmid_release sda_en/scl_en/busy/done=%b want 0000", {o_sda_en, o_scl_en, busy, done}); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc; logic b0;
    test_write(8'h5A);
    run(1'b1, 7'h27, 8'h00, -1, -1, cyc, b0);
    checks++; if (cyc !== 320 || out !== 8'h3C) begin errors++; $display("FAIL b2b_read cyc=%0d out=%h want 320 3c", cyc, out); end
  endtask

  task automatic test_stretch;
    int cyc; logic b0;
    t_stretch = 1'b1;
    run(1'b0, 7'h27, 8'hA5, -1, -1, cyc, b0);
    t_stretch = 1'b0;
`ifdef I2C_STRETCH_EN
    checks++; if (cyc < 338 || cyc > 342) begin errors++; $display("FAIL stretch_done_cycle got %0d want 338..342", cyc); end
`else
    checks++; if (cyc !== 320) begin errors++; $display("FAIL stretch_done_cycle got %0d want 320", cyc); end
`endif
    checks++; if (ack_err !== 1'b0 || mon_data !== 8'hA5) begin errors++; $display("FAIL stretch_xfer ack_err=%b data=%h want 0 a5", ack_err, mon_data); end
  endtask

  initial begin
    test_reset();
    test_write(8'hA5);
    test_read();
    test_nack();
    test_ignored_start();
    test_reset_mid();
    test_write(8'hA5);
    test_back_to_back();
    test_stretch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
